// File: rtl/reg_file_write_arbiter.sv
// Two-requester round-robin write arbiter for a 32x16 register file.
// One write per two cycles; writes to register 0 are granted but dropped.
module reg_file_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              zero_wr,
    output logic [CNT_W-1:0]  write_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               ptr, ptr_nxt;
    logic               cap_en, cap_sel;
    logic               gnt0_nxt, gnt1_nxt;
    logic               we_nxt, zw_nxt;
    logic [ADDR_W-1:0]  cap_addr;
    logic [DATA_W-1:0]  cap_data;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cap_en    = 1'b0;
        cap_sel   = 1'b0;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // Requester 0 wins when alone, or when both ask and the pointer names it.
                if (req0 && (!req1 || !ptr)) begin
                    state_nxt = WR0;
                    ptr_nxt   = 1'b1;
                    cap_en    = 1'b1;
                    cap_sel   = 1'b0;
                    gnt0_nxt  = 1'b1;
                end else if (req1) begin
                    state_nxt = WR1;
                    ptr_nxt   = 1'b0;
                    cap_en    = 1'b1;
                    cap_sel   = 1'b1;
                    gnt1_nxt  = 1'b1;
                end
            end
            WR0, WR1: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign cap_addr = cap_sel ? addr1 : addr0;
    assign cap_data = cap_sel ? data1 : data0;
    assign we_nxt   = cap_en && (cap_addr != '0);
    assign zw_nxt   = cap_en && (cap_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            RegWrite    <= 1'b0;
            zero_wr     <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            write_count <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt0     <= gnt0_nxt;
            gnt1     <= gnt1_nxt;
            RegWrite <= we_nxt;
            zero_wr  <= zw_nxt;
            if (cap_en) begin
                write_addr <= cap_addr;
                write_data <= cap_data;
            end
            // The register file commits on the edge that ends the WR cycle.
            if (RegWrite)
                write_count <= write_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Bench for reg_file_write_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model and a register file stub.
module tb_reg_file_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [4:0]  addr0 = '0, addr1 = '0;
    logic [15:0] data0 = '0, data1 = '0;
    logic        gnt0, gnt1, RegWrite, zero_wr;
    logic [4:0]  write_addr;
    logic [15:0] write_data;
    logic [7:0]  write_count;

    int vectors = 0;
    int miscompares = 0;

    reg_file_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .RegWrite(RegWrite),
        .write_addr(write_addr), .write_data(write_data),
        .zero_wr(zero_wr), .write_count(write_count)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT's write port
    logic [15:0] tb_rf [32];
    always @(posedge clk) if (RegWrite) tb_rf[write_addr] <= write_data;

    // Transaction-level model: a pending grant either commits or a new winner is picked
    logic        m_busy, m_g0, m_g1, m_we, m_zw, m_ptr;
    logic [4:0]  m_addr;
    logic [15:0] m_data;
    int          m_cnt;
    logic [15:0] m_rf [32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_g0 = 0; m_g1 = 0; m_we = 0; m_zw = 0; m_ptr = 0;
            m_addr = 0; m_data = 0; m_cnt = 0;
        end else if (m_busy) begin
            if (m_we) begin
                m_cnt = (m_cnt + 1) % 256;
                m_rf[m_addr] = m_data;
            end
            m_busy = 0; m_g0 = 0; m_g1 = 0; m_we = 0; m_zw = 0;
        end else if (req0 || req1) begin
            int w;
            w = (req0 && req1) ? int'(m_ptr) : (req1 ? 1 : 0);
            m_ptr  = (w == 0);
            m_addr = (w == 1) ? addr1 : addr0;
            m_data = (w == 1) ? data1 : data0;
            m_g0   = (w == 0);
            m_g1   = (w == 1);
            m_we   = (m_addr != 0);
            m_zw   = (m_addr == 0);
            m_busy = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison plus starvation watch
    int  w0 = 0, w1 = 0;
    logic cmp_en = 1'b0;
    always @(negedge rst_n) begin w0 = 0; w1 = 0; end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("gnt0", {31'b0, gnt0}, {31'b0, m_g0});
            check("gnt1", {31'b0, gnt1}, {31'b0, m_g1});
            check("RegWrite", {31'b0, RegWrite}, {31'b0, m_we});
            check("zero_wr", {31'b0, zero_wr}, {31'b0, m_zw});
            check("write_addr", {27'b0, write_addr}, {27'b0, m_addr});
            check("write_data", {16'b0, write_data}, {16'b0, m_data});
            check("write_count", {24'b0, write_count}, m_cnt);
            if (gnt0) w0 = 0; else if (req0) begin
                w0++;
                check("starve0", {31'b0, w0 > 4}, 0);
            end
            if (gnt1) w1 = 0; else if (req1) begin
                w1++;
                check("starve1", {31'b0, w1 > 4}, 0);
            end
        end
    end

    logic g0_exp [6] = '{1, 0, 0, 0, 1, 0};
    logic g1_exp [6] = '{0, 0, 1, 0, 0, 0};

    initial begin
        for (int i = 0; i < 32; i++) begin tb_rf[i] = 16'h0; m_rf[i] = 16'h0; end
        #1 rst_n = 1'b0;
        #1;
        check("rst_gnt0", {31'b0, gnt0}, 0);
        check("rst_RegWrite", {31'b0, RegWrite}, 0);
        check("rst_waddr", {27'b0, write_addr}, 0);
        check("rst_count", {24'b0, write_count}, 0);
        cmp_en = 1'b1;

        // Single write to register 10
        @(negedge clk); #2 rst_n = 1'b1; req0 = 1; addr0 = 5'd10; data0 = 16'h1234;
        @(negedge clk);
        check("sw_gnt0", {31'b0, gnt0}, 1);
        check("sw_we", {31'b0, RegWrite}, 1);
        check("sw_addr", {27'b0, write_addr}, 10);
        check("sw_data", {16'b0, write_data}, 32'h1234);
        #2 req0 = 0;
        @(negedge clk);
        check("sw_rf10", {16'b0, tb_rf[10]}, 32'h1234);
        check("sw_count", {24'b0, write_count}, 1);

        // Write to register 0 is dropped
        #2 req1 = 1; addr1 = 5'd0; data1 = 16'hFFFF;
        @(negedge clk);
        check("z_gnt1", {31'b0, gnt1}, 1);
        check("z_flag", {31'b0, zero_wr}, 1);
        check("z_we", {31'b0, RegWrite}, 0);
        #2 req1 = 0;
        @(negedge clk);
        check("z_rf0", {16'b0, tb_rf[0]}, 0);
        check("z_count", {24'b0, write_count}, 1);

        // Pointer points at 0 after req1's grant; then continuous contention alternates
        #2 req0 = 1; req1 = 1; addr0 = 5'd5; data0 = 16'h5678; addr1 = 5'd19; data1 = 16'h00AA;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_gnt0", {31'b0, gnt0}, {31'b0, g0_exp[k]});
            check("rr_gnt1", {31'b0, gnt1}, {31'b0, g1_exp[k]});
        end
        check("rr_count", {24'b0, write_count}, 4);
        check("rr_rf19", {16'b0, tb_rf[19]}, 32'h00AA);
        #2 req0 = 0; req1 = 0;

        // Reset during WR0 aborts the write
        @(negedge clk); #2 req0 = 1; addr0 = 5'd7; data0 = 16'hBEEF;
        @(negedge clk);
        check("mr_gnt0", {31'b0, gnt0}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_gnt0_drop", {31'b0, gnt0}, 0);
        check("mr_we_drop", {31'b0, RegWrite}, 0);
        check("mr_count", {24'b0, write_count}, 0);
        @(negedge clk);
        check("mr_rf7", {16'b0, tb_rf[7]}, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("mr_regnt", {31'b0, gnt0}, 1);
        check("mr_readdr", {27'b0, write_addr}, 7);
        #2 req0 = 0;

        // 256 committed writes from reset wrap the counter
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1; req0 = 1; addr0 = 5'd3; data0 = 16'h0C0C;
        repeat (510) @(negedge clk);
        check("wrap_255", {24'b0, write_count}, 255);
        repeat (2) @(negedge clk);
        check("wrap_0", {24'b0, write_count}, 0);
        #2 req0 = 0;

        // Randomized traffic honouring the hold-until-grant handshake
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #2;
            if (!req0) begin
                if ($urandom_range(2) == 0) begin
                    req0 = 1; addr0 = 5'($urandom); data0 = 16'($urandom);
                end
            end else if (gnt0) begin
                if ($urandom_range(1) == 0) req0 = 0;
                else begin addr0 = 5'($urandom); data0 = 16'($urandom); end
            end
            if (!req1) begin
                if ($urandom_range(2) == 0) begin
                    req1 = 1; addr1 = 5'($urandom); data1 = 16'($urandom);
                end
            end else if (gnt1) begin
                if ($urandom_range(1) == 0) req1 = 0;
                else begin addr1 = 5'($urandom); data1 = 16'($urandom); end
            end
            if ($urandom_range(499) == 0) begin
                rst_n = 1'b0; #1 rst_n = 1'b1;
            end
        end
        req0 = 0; req1 = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 32; i++) check("rf_final", {16'b0, tb_rf[i]}, {16'b0, m_rf[i]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_write_arbiter.md
REG_FILE_WRITE_ARBITER -- requirements
Module: reg_file_write_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req0 / req1  input  1 each  write request from requester 0 / 1.
REQ-005 Port: addr0 / addr1  input  5 each  target register for requester 0 / 1.
REQ-006 Port: data0 / data1  input  16 each  write data for requester 0 / 1.
REQ-007 Port: gnt0 / gnt1  output  1 each  one-cycle grant; the transfer completes on the rising edge at which gnt is 1.
REQ-008 Port: RegWrite  output  1  write enable to the 32x16 register file.
REQ-009 Port: write_addr  output  5  register file write address.
REQ-010 Port: write_data  output  16  register file write data.
REQ-011 Port: zero_wr  output  1  one-cycle flag: the granted write targeted register 0 and was dropped.
REQ-012 Port: write_count  output  8  count of committed register file writes.

Function
REQ-013 All outputs SHALL be registered, driven from the FSM state and the output registers.
REQ-014 FSM states SHALL be IDLE, WR0 and WR1.
REQ-015 IDLE, no req: stay in IDLE.
REQ-016 IDLE, at least one req: go to WRx for the winner x and capture addrx/datax into the output registers.
REQ-017 WR0/WR1 SHALL always return to IDLE after exactly one cycle, giving at most one write per 2 cycles.
REQ-018 In WRx: gntx=1 and the other grant=0; RegWrite=1 unless the captured address is 0; write_addr/write_data hold the captured values.
REQ-019 Latency: a req sampled high in IDLE at edge N SHALL give gnt and RegWrite high in cycle N..N+1; the register file commits at edge N+1.
REQ-020 Arbitration SHALL be round-robin with a 1-bit priority pointer.
REQ-021 Only one req high: that requester wins, regardless of the pointer.
REQ-022 Both req high: the requester named by the pointer wins.
REQ-023 On entering WRx, the pointer SHALL be set to the other requester.
REQ-024 Requesters SHALL hold req/addr/data stable until they see gnt, and SHALL deassert or change req at the edge where gnt=1.
REQ-025 A req still high in the IDLE cycle after a grant SHALL be treated as a new request.
REQ-026 Captured address 0: RegWrite=0, zero_wr=1, gnt still asserted, write_count unchanged.
REQ-027 write_count SHALL increment by 1 at the end of each WR cycle with RegWrite=1, and SHALL wrap from 255 to 0.
REQ-028 When not in WRx: gnt0=gnt1=0, RegWrite=0, zero_wr=0, and write_addr/write_data hold their last values.
REQ-029 req asserted during a WR state SHALL be ignored until the following IDLE cycle.
REQ-030 Requests are never lost: a held req SHALL be granted within 4 cycles.

Reset
REQ-031 While rst_n=0, the block SHALL immediately, without waiting for clk, hold: state=IDLE, pointer=0, gnt0=gnt1=0, RegWrite=0, zero_wr=0, write_addr=0, write_data=0, write_count=0.
REQ-032 Reset asserted during WRx SHALL abort the write with no commit and no completed grant; the requester SHALL re-present.
REQ-033 The first rising edge after rst_n goes high SHALL evaluate requests normally from IDLE.

Verification
REQ-034 Single write: req0=1, addr0=10, data0=16'h1234 after reset -> next cycle gnt0=1, RegWrite=1, write_addr=10, write_data=16'h1234; register 10 reads 16'h1234; write_count=1.
REQ-035 Contention: req0 and req1 held continuously (addr0=5/data0=16'h5678, addr1=19/data1=16'h00AA) -> grants alternate gnt0, gnt1, gnt0, ... with an IDLE cycle between each.
REQ-036 Zero target: req1=1, addr1=0, data1=16'hFFFF -> gnt1=1, zero_wr=1, RegWrite=0; register 0 unchanged; write_count unchanged.
REQ-037 Wrap: 256 committed writes from reset -> write_count returns to 0.
REQ-038 Mid-op reset: rst_n pulled low during WR0 -> RegWrite and gnt0 drop immediately; target register unchanged; write_count=0.
REQ-039 Pointer check: req1 alone granted, then both req high -> gnt0 wins the next arbitration.
